// File: rtl/brent_kung_recover.sv
// Recovers B = SUM - A from an adder's sum and one addend using a two-stage
// pipelined Brent-Kung prefix network, with valid/ready on both sides.
module brent_kung_recover #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int N   = WIDTH + 1;
  localparam int LVL = $clog2(N);

  logic [N-1:0] op_b;
  logic [N-1:0] bit_p;
  logic [N-1:0] up_g;
  logic [N-1:0] up_p;

  logic         s1_valid;
  logic [N-1:0] s1_p;
  logic [N-1:0] s1_g;
  logic [N-1:0] s1_gp;

  logic [N-1:0] dn_g;
  logic [N-1:0] diff;
  logic         diff_err;
  logic         s2_adv;

  // Up-sweep: node i (with i+1 a multiple of 2d) absorbs the group ending at i-d.
  // NOTE: every combinational output gets a full default before the loops, so no latch can be inferred.
  always_comb begin
    op_b    = {1'b1, ~in_a};
    bit_p   = in_sum ^ op_b;
    up_g    = in_sum & op_b;
    up_p    = bit_p;
    up_g[0] = up_g[0] | bit_p[0];  // carry-in of 1 folded into bit 0
    for (int l = 0; l < LVL; l++) begin
      for (int i = 0; i < N; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          up_g[i] = up_g[i] | (up_p[i] & up_g[i - (1 << l)]);
          up_p[i] = up_p[i] & up_p[i - (1 << l)];
        end
      end
    end
  end

  // Down-sweep: fill the odd-multiple positions from the already-complete prefixes.
  always_comb begin
    dn_g = s1_g;
    for (int l = LVL - 1; l >= 0; l--) begin
      for (int i = 0; i < N; i++) begin
        if ((((i + 1) % (2 << l)) == (1 << l)) && ((i + 1) > (2 << l))) begin
          dn_g[i] = dn_g[i] | (s1_gp[i] & dn_g[i - (1 << l)]);
        end
      end
    end
    diff     = s1_p ^ {dn_g[N-2:0], 1'b1};
    diff_err = ~dn_g[N-1] | diff[WIDTH];
  end

  assign s2_adv   = ~out_valid | out_ready;
  assign in_ready = ~s1_valid | s2_adv;

  // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_p      <= '0;
      s1_g      <= '0;
      s1_gp     <= '0;
      out_valid <= 1'b0;
      out_b     <= '0;
      out_err   <= 1'b0;
      err_count <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_p  <= bit_p;
          s1_g  <= up_g;
          s1_gp <= up_p;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_b   <= diff[WIDTH-1:0];
          out_err <= diff_err;
        end
      end
      if (out_valid && out_ready && out_err && (err_count != '1)) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_brent_kung_recover.sv
// Randomized self-checking bench: scoreboard of SUM - A computed with integer
// arithmetic, plus directed latency, backpressure, reset and saturation cases.
module tb_brent_kung_recover;

  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W:0]   in_sum = '0;
  logic [W-1:0] in_a = '0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, out_err;
  logic [W-1:0] out_b;
  logic [7:0]   err_count;
  logic         in_ready_s, out_valid_s, out_err_s;
  logic [W-1:0] out_b_s;
  logic [1:0]   err_count_s;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W:0]   exp_q[$];
  int           model_cnt   = 0;
  int           model_cnt_s = 0;
  logic         hold_prev   = 1'b0;
  logic [W:0]   held;
  bit           rand_ready  = 1'b0;

  always #5 clk = ~clk;

  brent_kung_recover #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_a(in_a), .out_valid(out_valid), .out_ready(out_ready),
    .out_b(out_b), .out_err(out_err), .err_count(err_count)
  );

  brent_kung_recover #(.WIDTH(W), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_sum(in_sum), .in_a(in_a), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_b(out_b_s), .out_err(out_err_s), .err_count(err_count_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer difference; error when outside [0, 2^W-1].
  function automatic logic [W:0] model(input logic [W:0] s, input logic [W-1:0] a);
    int d;
    d = int'(s) - int'(a);
    return {(d < 0) || (d >= (1 << W)), d[W-1:0]};
  endfunction

  task automatic cycle(input logic v, input logic [W:0] s, input logic [W-1:0] a,
                       input logic rdy, output logic acc);
    logic [W:0] e;
    in_valid = v; in_sum = s; in_a = a; out_ready = rdy;
    #1;
    check("err_count", err_count, model_cnt);
    check("err_count_sat", err_count_s, model_cnt_s);
    if (hold_prev) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_err, out_b}, held);
    end
    if (out_valid && rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_b", out_b, e[W-1:0]);
        check("out_err", out_err, e[W]);
        if (e[W]) begin
          if (model_cnt < 255) model_cnt++;
          if (model_cnt_s < 3) model_cnt_s++;
        end
      end
    end
    hold_prev = out_valid & ~rdy;
    held      = {out_err, out_b};
    acc = v & in_ready;
    if (acc) exp_q.push_back(model(s, a));
    @(posedge clk); #1;
  endtask

  function automatic logic pick_ready();
    return rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  endfunction

  task automatic send(input logic [W:0] s, input logic [W-1:0] a);
    logic acc;
    int   tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 64) begin
      cycle(1'b1, s, a, pick_ready(), acc);
      tries++;
    end
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b1, acc);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 64) begin
      idle(1);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_one(input logic [W:0] s, input logic [W-1:0] a,
                          input logic [W-1:0] eb, input logic ee);
    logic acc;
    cycle(1'b1, s, a, 1'b1, acc);
    check("accept", acc, 1);
    check("lat1_valid", out_valid, 0);
    cycle(1'b0, '0, '0, 1'b1, acc);
    check("lat2_valid", out_valid, 1);
    check("dir_b", out_b, eb);
    check("dir_err", out_err, ee);
    idle(1);
  endtask

  initial begin
    logic acc;
    logic [W-1:0] ra, rb;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;

    send_one(13'h0005, 12'h003, 12'h002, 1'b0);
    send_one(13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    send_one(13'h0002, 12'h003, 12'hFFF, 1'b1);
    check("cnt_underflow", err_count, 1);
    send_one(13'h1FFF, 12'h000, 12'hFFF, 1'b1);
    check("cnt_overflow", err_count, 2);

    // Backpressure: out_ready low while streaming four beats.
    cycle(1'b1, 13'h0100, 12'h001, 1'b0, acc); check("bp_acc0", acc, 1);
    cycle(1'b1, 13'h0200, 12'h002, 1'b0, acc); check("bp_acc1", acc, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 13'h0300, 12'h003, 1'b0, acc);
      check("bp_ready_low", acc, 0);
    end
    cycle(1'b1, 13'h0300, 12'h003, 1'b1, acc); check("bp_acc2", acc, 1);
    send(13'h0004, 12'h005);
    drain();

    // Asynchronous reset with two beats in flight.
    cycle(1'b1, 13'h0010, 12'h003, 1'b1, acc);
    cycle(1'b1, 13'h0001, 12'h005, 1'b1, acc);
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    #2; rst = 1'b1; #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt", err_count, 0);
    check("async_rst_ready", in_ready, 1);
    exp_q.delete();
    model_cnt = 0; model_cnt_s = 0; hold_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check("no_stale", out_valid, 0);
    end

    // Saturation of the narrow counter.
    for (int i = 1; i <= 5; i++) send(13'h0000, W'(i));
    drain();
    check("sat_cnt2", err_count_s, 3);
    check("sat_cnt8", err_count, 5);
    idle(2);
    check("sat_hold", err_count_s, 3);

    // Consistent pairs: SUM = A + B, random bubbles and backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if ($urandom_range(0, 4) == 0) cycle(1'b0, '0, '0, pick_ready(), acc);
      send({1'b0, ra} + {1'b0, rb}, ra);
    end
    drain();
    check("pairs_cnt", err_count, 5);

    // Arbitrary operands, exercising error cases and 8-bit saturation.
    for (int i = 0; i < 2000; i++) send(13'($urandom), W'($urandom));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
